// File: rtl/peripheral_bin2bcd.sv
// Memory-mapped 32-bit binary to 10-digit BCD converter, one double-dabble step per clock.
// Latency: conversion takes 32 cycles from the accepted start; register reads return on the next edge.
// No backpressure: writes and reads complete in one cycle, and BIN/CTRL writes are ignored while busy.
module peripheral_bin2bcd #(
  parameter int clk_freq = 25000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [2:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state;
  logic [31:0] bin;
  logic [31:0] shreg;
  logic [39:0] acc;
  logic [5:0]  step;
  logic [31:0] bcd_lo;
  logic [7:0]  bcd_hi;

  logic        wr_en;
  logic        rd_en;
  logic        busy;
  logic        done;
  logic        start_ok;
  logic [39:0] acc_adj;
  logic [39:0] acc_next;
  logic [31:0] rd_mux;
  logic        unused_msb;

  assign wr_en    = cs & wr;
  assign rd_en    = cs & rd;
  assign busy     = (state == ST_SHIFT);
  assign done     = (state == ST_DONE);
  // A start is only honoured outside a running conversion.
  assign start_ok = wr_en && (addr == 3'd1) && d_in[0] && !busy;

  // Add-3 correction on every BCD digit that would overflow when doubled.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 10; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) begin
        acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end
    end
  end

  // The top digit can never exceed 4 for a 32-bit input, so its MSB is never shifted out with data.
  assign acc_next   = {acc_adj[38:0], shreg[31]};
  assign unused_msb = acc_adj[39];

  // Read data selection by word offset; unmapped and write-only offsets read zero.
  always_comb begin
    rd_mux = 32'd0;
    case (addr)
      3'd0:    rd_mux = bin;
      3'd2:    rd_mux = {30'd0, busy, done};
      3'd3:    rd_mux = bcd_lo;
      3'd4:    rd_mux = {24'd0, bcd_hi};
      default: rd_mux = 32'd0;
    endcase
  end

  // Control FSM, conversion datapath and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      bin    <= 32'd0;
      shreg  <= 32'd0;
      acc    <= 40'd0;
      step   <= 6'd0;
      bcd_lo <= 32'd0;
      bcd_hi <= 8'd0;
    end else begin
      case (state)
        ST_SHIFT: begin
          acc   <= acc_next;
          shreg <= {shreg[30:0], 1'b0};
          step  <= step + 6'd1;
          if (step == 6'd31) begin
            state  <= ST_DONE;
            bcd_lo <= acc_next[31:0];
            bcd_hi <= acc_next[39:32];
          end
        end
        default: begin
          if (wr_en && (addr == 3'd0)) begin
            bin <= d_in;
          end
          if (start_ok) begin
            state <= ST_SHIFT;
            shreg <= bin;
            acc   <= 40'd0;
            step  <= 6'd0;
          end
        end
      endcase
    end
  end

  // Registered read port: updates only on a selected read, otherwise holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_out <= 32'd0;
    end else if (rd_en) begin
      d_out <= rd_mux;
    end
  end

endmodule

// File: tb/tb_peripheral_bin2bcd.sv
// Randomised and directed bench for peripheral_bin2bcd with a queue-based scoreboard.
// Expected read data comes from an arithmetic model tracked per clock cycle.
// The monitor compares every selected read one cycle later and checks d_out holds otherwise.
module tb_peripheral_bin2bcd;

  logic        clk;
  logic        resetn;
  logic [31:0] d_in;
  logic        cs;
  logic [2:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;

  peripheral_bin2bcd #(.clk_freq(25000000)) dut (
    .clk   (clk),
    .resetn(resetn),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [31:0] m_bin;
  logic [31:0] m_lo;
  logic [31:0] m_hi;
  logic [31:0] m_pend_lo;
  logic [31:0] m_pend_hi;
  logic        m_busy;
  logic        m_done;
  int          m_start;

  logic [31:0] sb[$];
  logic        rd_seen;
  logic [31:0] last_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal digits by repeated division; digit i lands in nibble i.
  function automatic logic [63:0] to_bcd(input logic [31:0] v);
    logic [63:0] r;
    longint      x;
    r = 64'd0;
    x = longint'(v);
    for (int i = 0; i < 10; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_bin;
      3'd2:    return {30'd0, m_busy, m_done};
      3'd3:    return m_lo;
      3'd4:    return m_hi;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_bin  = 32'd0;
    m_lo   = 32'd0;
    m_hi   = 32'd0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_start = 0;
  endtask

  // Brings the model to the state visible after the most recent clock edge.
  task automatic model_sync();
    if (m_busy && (cyc >= m_start + 32)) begin
      m_busy = 1'b0;
      m_done = 1'b1;
      m_lo   = m_pend_lo;
      m_hi   = m_pend_hi;
    end
  endtask

  // One bus cycle: model predicts, inputs drive, then advance past the edge.
  task automatic bus(input logic c, input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
    logic [63:0] b;
    model_sync();
    if (c && r) sb.push_back(model_read(a));
    if (c && w && !m_busy) begin
      if (a == 3'd0) m_bin = d;
      if (a == 3'd1 && d[0]) begin
        b         = to_bcd(m_bin);
        m_pend_lo = b[31:0];
        m_pend_hi = {24'd0, b[39:32]};
        m_busy    = 1'b1;
        m_done    = 1'b0;
        m_start   = cyc + 1;
      end
    end
    cs = c; wr = w; rd = r; addr = a; d_in = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 3'd0; d_in = 32'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    bus(1'b1, 1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (m_busy && n < 64) begin
      rd_reg(3'd2);
      n++;
    end
  endtask

  task automatic read_results();
    rd_reg(3'd2);
    rd_reg(3'd3);
    rd_reg(3'd4);
    rd_reg(3'd0);
  endtask

  task automatic convert(input logic [31:0] v);
    wr_reg(3'd0, v);
    wr_reg(3'd1, 32'd1);
    wait_done();
    read_results();
  endtask

  task automatic pulse_reset();
    idle(1);
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_dout", d_out, 32'd0);
    check("reset_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: notes selected reads at the edge, compares half a cycle later.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) rd_seen <= 1'b0;
    else         rd_seen <= cs & rd;
  end

  always @(negedge clk) begin
    if (!resetn) begin
      last_dout = 32'd0;
    end else if (rd_seen) begin
      if (sb.size() == 0) begin
        check("sb_underflow", d_out, 32'hDEAD_BEEF);
      end else begin
        check("read_data", d_out, sb.pop_front());
      end
      last_dout = d_out;
    end else begin
      check("dout_hold", d_out, last_dout);
    end
  end

  initial begin
    logic [31:0] v;
    int          k;
    resetn = 1'b0;
    cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 3'd0; d_in = 32'd0;
    model_reset();
    last_dout = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout_init", d_out, 32'd0);
    resetn = 1'b1;
    idle(2);

    // Reset state of every offset
    for (int a = 0; a < 8; a++) rd_reg(3'(a));

    // Zero input, then the two documented values
    convert(32'd0);
    convert(32'h00BC614E);
    convert(32'hFFFFFFFF);

    // Start with bit0 clear must do nothing
    wr_reg(3'd0, 32'd55);
    wr_reg(3'd1, 32'hFFFF_FFFE);
    idle(3);
    read_results();

    // Writes and starts during SHIFT are ignored; previous results still visible
    wr_reg(3'd0, 32'd99);
    wr_reg(3'd1, 32'd1);
    idle(4);
    wr_reg(3'd0, 32'd7);
    wr_reg(3'd1, 32'd1);
    rd_reg(3'd2);
    rd_reg(3'd0);
    rd_reg(3'd3);
    rd_reg(3'd4);
    wait_done();
    read_results();

    // Reset in the middle of a conversion, then rerun
    wr_reg(3'd0, 32'd1000);
    wr_reg(3'd1, 32'd1);
    idle(9);
    pulse_reset();
    for (int a = 0; a < 8; a++) rd_reg(3'(a));
    convert(32'd1000);

    // Strobes without chip select
    bus(1'b0, 1'b1, 1'b0, 3'd0, 32'h1234_5678);
    bus(1'b0, 1'b1, 1'b0, 3'd1, 32'd1);
    bus(1'b0, 1'b0, 1'b1, 3'd3, 32'd0);
    idle(2);
    read_results();

    // DONE -> SHIFT restart without a new BIN
    wr_reg(3'd1, 32'd1);
    wait_done();
    read_results();

    // Randomised conversions with traffic while busy
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999);
        2:       v = 32'hFFFF_FFFF - $urandom_range(0, 1000);
        default: v = 32'd1 << $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 3) != 0) wr_reg(3'd0, v);
      bus(1'($urandom_range(0, 1)), 1'b1, 1'b0, 3'($urandom_range(2, 7)), $urandom);
      wr_reg(3'd1, 32'd1);
      k = 0;
      while (m_busy && k < 48) begin
        bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), $urandom);
        k++;
      end
      wait_done();
      read_results();
    end

    idle(3);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
